// File: rtl/mux_n1_stream.sv
// mux_n1_stream
// N-input, WIDTH-bit registered stream multiplexer with valid/ready handshaking
// on every input channel and on the output, plus a one-entry output register.
//
// Selection modes (sampled combinationally every cycle):
//   mode=0 : external select; channel `sel` is granted when it is valid.
//   mode=1 : round-robin; the search starts at the pointer and wraps, and the
//            pointer moves past the winner on every round-robin transfer.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_data    flattened channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational, one-hot or zero)
//   sel        channel select for mode=0
//   mode       0 = external select, 1 = round-robin
//   out        registered output data
//   out_valid  output register holds a valid word
//   out_ready  consumer accepts the output word this cycle
//   out_src    index of the channel that supplied `out`
module mux_n1_stream #(
    parameter int WIDTH = 2,
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [SEL_W-1:0]   sel,
    input  logic               mode,
    output logic [WIDTH-1:0]   out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   out_src
);

    logic [WIDTH-1:0] out_q,       out_d;
    logic [SEL_W-1:0] out_src_q,   out_src_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] ptr_q,       ptr_d;

    logic             load;
    logic             fixed_valid;
    logic             rr_found;
    logic [SEL_W-1:0] rr_grant;
    logic             grant_valid;
    logic [SEL_W-1:0] grant;
    logic [WIDTH-1:0] mux_data;
    logic             xfer;

    // The register can take a word when it is empty or being drained now,
    // which gives full throughput with no bubble on drain-and-refill.
    assign load = !out_valid_q || out_ready;

    // External select: out-of-range sel never matches a channel, so it
    // yields no grant without indexing past the in_valid vector.
    always_comb begin
        fixed_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (int'(sel) == i) begin
                fixed_valid = in_valid[i];
            end
        end
    end

    // Round-robin search: visit ptr, ptr+1, ... wrapping modulo N and take
    // the first valid channel.
    always_comb begin
        int idx;
        idx      = 0;
        rr_found = 1'b0;
        rr_grant = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!rr_found && in_valid[idx]) begin
                rr_found = 1'b1;
                rr_grant = SEL_W'(idx);
            end
        end
    end

    assign grant       = mode ? rr_grant : sel;
    assign grant_valid = mode ? rr_found : fixed_valid;

    // A granted channel is always valid, so a grant plus load is a transfer.
    assign xfer = !rst && load && grant_valid;

    always_comb begin
        in_ready = '0;
        mux_data = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(grant) == i) begin
                in_ready[i] = xfer;
                mux_data    = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        out_d       = out_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_d       = mux_data;
            out_src_d   = grant;
            out_valid_d = 1'b1;
            if (mode) begin
                ptr_d = (int'(grant) == N - 1) ? '0 : grant + 1'b1;
            end
        end else if (load) begin
            // Word consumed (or register already empty) with nothing to
            // replace it: drop valid but keep data/src for observability.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            out_src_q   <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_q       <= out_d;
            out_src_q   <= out_src_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out       = out_q;
    assign out_src   = out_src_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_n1_stream.sv
module tb_mux_n1_stream;

    localparam int WIDTH = 2;
    localparam int N     = 4;
    localparam int SEL_W = 3;

    logic               clk;
    logic               rst;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [SEL_W-1:0]   sel;
    logic               mode;
    logic [WIDTH-1:0]   out;
    logic               out_valid;
    logic               out_ready;
    logic [SEL_W-1:0]   out_src;

    int checks = 0;
    int errors = 0;

    mux_n1_stream #(
        .WIDTH (WIDTH),
        .N     (N),
        .SEL_W (SEL_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .mode      (mode),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_src   (out_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [WIDTH-1:0] v);
        in_data[ch*WIDTH +: WIDTH] = v;
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 4'b1111;
        sel       = '0;
        mode      = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) set_ch(i, WIDTH'(i));

        // Reset held for two cycles with every channel valid.
        #1;
        chk("rst_in_ready_comb", 32'(in_ready), 32'h0);
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out", 32'(out), 32'h0);
        chk("rst_out_src", 32'(out_src), 32'h0);

        // Round-robin with all channels valid: 0,1,2,3,0,1 back to back.
        rst = 1'b0;
        #1;
        chk("rr_first_ready", 32'(in_ready), 32'h1);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("rr_full_src%0d", k), 32'(out_src), 32'(k % 4));
            chk($sformatf("rr_full_out%0d", k), 32'(out), 32'(k % 4));
            chk($sformatf("rr_full_vld%0d", k), 32'(out_valid), 32'h1);
            chk($sformatf("rr_full_rdy%0d", k), 32'(in_ready), 32'(1 << ((k + 1) % 4)));
        end
        // One more grant (ch2) leaves the pointer at 3.
        tick();
        chk("rr_to_ptr3_src", 32'(out_src), 32'h2);

        // Sparse round-robin from ptr=3 with only ch0 and ch2 valid.
        in_valid = 4'b0101;
        #1;
        chk("rr_sparse_rdy0", 32'(in_ready), 32'h1);
        tick();
        chk("rr_sparse_src0", 32'(out_src), 32'h0);
        chk("rr_sparse_rdy1", 32'(in_ready), 32'h4);
        tick();
        chk("rr_sparse_src1", 32'(out_src), 32'h2);
        chk("rr_sparse_rdy2", 32'(in_ready), 32'h1);
        tick();
        chk("rr_sparse_src2", 32'(out_src), 32'h0);
        chk("rr_sparse_out2", 32'(out), 32'h0);

        // Fixed select of channel 2, then an out-of-range select.
        mode     = 1'b0;
        sel      = 3'd2;
        in_valid = 4'b1111;
        #1;
        chk("fix_sel2_rdy", 32'(in_ready), 32'h4);
        tick();
        chk("fix_sel2_out", 32'(out), 32'h2);
        chk("fix_sel2_src", 32'(out_src), 32'h2);
        chk("fix_sel2_vld", 32'(out_valid), 32'h1);
        sel = 3'd5;
        #1;
        chk("fix_sel5_rdy", 32'(in_ready), 32'h0);
        tick();
        chk("fix_sel5_vld", 32'(out_valid), 32'h0);
        chk("fix_sel5_out_hold", 32'(out), 32'h2);
        chk("fix_sel5_src_hold", 32'(out_src), 32'h2);

        // Backpressure: word A=01 from ch1 held for three cycles.
        sel = 3'd1;
        set_ch(1, 2'b01);
        tick();
        chk("bp_load_out", 32'(out), 32'h1);
        chk("bp_load_src", 32'(out_src), 32'h1);
        out_ready = 1'b0;
        set_ch(1, 2'b11);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp_rdy%0d", k), 32'(in_ready), 32'h0);
            tick();
            chk($sformatf("bp_out%0d", k), 32'(out), 32'h1);
            chk($sformatf("bp_src%0d", k), 32'(out_src), 32'h1);
            chk($sformatf("bp_vld%0d", k), 32'(out_valid), 32'h1);
        end
        // Drain and refill on the same edge.
        out_ready = 1'b1;
        sel       = 3'd3;
        #1;
        chk("bp_refill_rdy", 32'(in_ready), 32'h8);
        tick();
        chk("bp_refill_out", 32'(out), 32'h3);
        chk("bp_refill_src", 32'(out_src), 32'h3);
        chk("bp_refill_vld", 32'(out_valid), 32'h1);

        // Pointer (1 after the sparse test) survives the mode=0 interlude.
        mode = 1'b1;
        #1;
        chk("ptr_keep_rdy", 32'(in_ready), 32'h2);
        tick();
        chk("ptr_keep_src", 32'(out_src), 32'h1);
        chk("ptr_keep_out", 32'(out), 32'h3);

        // Reset while a word is held under backpressure.
        out_ready = 1'b0;
        rst       = 1'b1;
        #1;
        chk("midrst_rdy", 32'(in_ready), 32'h0);
        tick();
        chk("midrst_vld", 32'(out_valid), 32'h0);
        chk("midrst_out", 32'(out), 32'h0);
        chk("midrst_src", 32'(out_src), 32'h0);
        rst = 1'b0;
        #1;
        chk("midrst_ptr0_rdy", 32'(in_ready), 32'h1);
        tick();
        chk("midrst_next_src", 32'(out_src), 32'h0);
        chk("midrst_next_vld", 32'(out_valid), 32'h1);
        chk("midrst_full_rdy", 32'(in_ready), 32'h0);
        out_ready = 1'b1;
        #1;
        chk("midrst_drain_rdy", 32'(in_ready), 32'h2);
        tick();
        chk("midrst_drain_src", 32'(out_src), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
